bram_byte_lsu_adapter: RTL and testbench

- Bridges the core's LSU (32-bit load/store requests, byte/half/word size) to the 8-bit simple-dual-port block RAM.
- The block RAM has 14-bit byte address, port A write, port B read with registered output, and 1-cycle read latency.
- Serialises each request into per-byte BRAM accesses, little-endian, and assembles and sign-extends load data.
- Returns one response per request over a valid/ready handshake. Both BRAM ports are clocked by this block's clock.

---
 rtl/bram_byte_lsu_adapter.sv | 162 ++++++++++++++++
 tb/tb_bram_byte_lsu_adapter.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_byte_lsu_adapter.sv
// rtl/bram_byte_lsu_adapter.sv - LSU to 8-bit simple-dual-port BRAM byte-serialising adapter
module bram_byte_lsu_adapter #(
   parameter int ADDR_W = 14,
   parameter int TAG_W  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   input  logic [TAG_W-1:0]  req_tag,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [31:0]       resp_rdata,
   output logic [TAG_W-1:0]  resp_tag,
   output logic              resp_err,
   output logic              bram_ena,
   output logic              bram_wea,
   output logic [ADDR_W-1:0] bram_addra,
   output logic [7:0]        bram_dina,
   output logic              bram_enb,
   output logic [ADDR_W-1:0] bram_addrb,
   input  logic [7:0]        bram_doutb
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_WR    = 3'd1;
   localparam logic [2:0] S_RD    = 3'd2;
   localparam logic [2:0] S_DRAIN = 3'd3;
   localparam logic [2:0] S_RESP  = 3'd4;

   logic [2:0]        state;
   logic [ADDR_W-1:0] addr_r;
   logic [31:0]       wdata_r;
   logic [1:0]        size_r;
   logic              uns_r;
   logic [TAG_W-1:0]  tag_r;
   logic              err_r;
   logic [1:0]        cnt;
   logic [1:0]        last;
   logic              cap_en;
   logic [1:0]        cap_idx;
   logic [31:0]       rbuf;
   logic [31:0]       rbuf_nxt;
   logic [31:0]       rdata_r;
   logic              req_err;
   logic [1:0]        req_last;
   logic [ADDR_W-1:0] byte_addr;

   // Sign/zero-extend the little-endian assembled bytes according to access size
   function automatic logic [31:0] extend(input logic [31:0] raw, input logic [1:0] size,
                                          input logic uns);
      logic [31:0] v;
      case (size)
         2'd0:    v = {{24{raw[7] & ~uns}}, raw[7:0]};
         2'd1:    v = {{16{raw[15] & ~uns}}, raw[15:0]};
         default: v = raw;
      endcase
      return v;
   endfunction

   // Decode byte count and alignment/size legality of the incoming request
   always_comb begin
      req_last = 2'd3;
      req_err  = 1'b0;
      case (req_size)
         2'd0: req_last = 2'd0;
         2'd1: begin
            req_last = 2'd1;
            req_err  = req_addr[0];
         end
         2'd2: req_err = (req_addr[1:0] != 2'b00);
         default: req_err = 1'b1;
      endcase
   end

   // Merge the byte returned by the BRAM (registered output, one cycle behind its issue)
   always_comb begin
      rbuf_nxt = rbuf;
      if (cap_en) rbuf_nxt[{cap_idx, 3'b000} +: 8] = bram_doutb;
   end

   assign byte_addr = addr_r + {{(ADDR_W-2){1'b0}}, cnt};

   assign req_ready  = (state == S_IDLE);
   assign bram_ena   = (state == S_WR);
   assign bram_wea   = (state == S_WR);
   assign bram_addra = (state == S_WR) ? byte_addr : '0;
   assign bram_dina  = (state == S_WR) ? wdata_r[{cnt, 3'b000} +: 8] : 8'd0;
   assign bram_enb   = (state == S_RD);
   assign bram_addrb = (state == S_RD) ? byte_addr : '0;
   assign resp_valid = (state == S_RESP);
   assign resp_rdata = (state == S_RESP) ? rdata_r : 32'd0;
   assign resp_tag   = (state == S_RESP) ? tag_r : '0;
   assign resp_err   = (state == S_RESP) & err_r;

   // Request sequencing: accept, per-byte write or read issue, drain, response hold
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= S_IDLE;
         addr_r  <= '0;
         wdata_r <= 32'd0;
         size_r  <= 2'd0;
         uns_r   <= 1'b0;
         tag_r   <= '0;
         err_r   <= 1'b0;
         cnt     <= 2'd0;
         last    <= 2'd0;
         cap_en  <= 1'b0;
         cap_idx <= 2'd0;
         rbuf    <= 32'd0;
         rdata_r <= 32'd0;
      end else begin
         rbuf   <= rbuf_nxt;
         cap_en <= 1'b0;
         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  addr_r  <= req_addr;
                  wdata_r <= req_wdata;
                  size_r  <= req_size;
                  uns_r   <= req_unsigned;
                  tag_r   <= req_tag;
                  err_r   <= req_err;
                  cnt     <= 2'd0;
                  last    <= req_last;
                  rbuf    <= 32'd0;
                  rdata_r <= 32'd0;
                  // Errors pass through DRAIN so the response lands one edge after
                  // accept without touching either BRAM port.
                  if (req_err)     state <= S_DRAIN;
                  else if (req_we) state <= S_WR;
                  else             state <= S_RD;
               end
            end
            S_WR: begin
               if (cnt == last) state <= S_RESP;
               else             cnt   <= cnt + 2'd1;
            end
            S_RD: begin
               cap_en  <= 1'b1;
               cap_idx <= cnt;
               if (cnt == last) state <= S_DRAIN;
               else             cnt   <= cnt + 2'd1;
            end
            S_DRAIN: begin
               if (!err_r) rdata_r <= extend(rbuf_nxt, size_r, uns_r);
               state <= S_RESP;
            end
            S_RESP: begin
               if (resp_ready) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bram_byte_lsu_adapter.sv
// tb/tb_bram_byte_lsu_adapter.sv - self-checking bench for bram_byte_lsu_adapter
module tb_bram_byte_lsu_adapter;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_we, req_unsigned;
   logic [1:0]  req_size;
   logic [13:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_tag;
   logic        resp_valid, resp_ready, resp_err;
   logic [31:0] resp_rdata;
   logic [3:0]  resp_tag;
   logic        bram_ena, bram_wea, bram_enb;
   logic [13:0] bram_addra, bram_addrb;
   logic [7:0]  bram_dina;
   logic [7:0]  bram_doutb = 8'd0;

   int checks = 0;
   int failures = 0;

   logic [7:0]  mem     [0:16383];
   logic [7:0]  ref_mem [0:16383];
   logic [21:0] wr_log[$];
   logic [13:0] rd_log[$];

   always #5 clk = ~clk;

   bram_byte_lsu_adapter #(.ADDR_W(14), .TAG_W(4)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_tag(req_tag),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
      .resp_tag(resp_tag), .resp_err(resp_err),
      .bram_ena(bram_ena), .bram_wea(bram_wea), .bram_addra(bram_addra),
      .bram_dina(bram_dina), .bram_enb(bram_enb), .bram_addrb(bram_addrb),
      .bram_doutb(bram_doutb)
   );

   // Block RAM: write port A, registered read port B
   always @(posedge clk) begin
      if (bram_ena && bram_wea) mem[bram_addra] <= bram_dina;
      if (bram_enb) bram_doutb <= mem[bram_addrb];
   end

   // Port activity monitor
   always @(posedge clk) begin
      if (bram_ena) wr_log.push_back({bram_addra, bram_dina});
      if (bram_enb) rd_log.push_back(bram_addrb);
   end

   function automatic int nbytes(input logic [1:0] size);
      return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
   endfunction

   function automatic bit model_err(input logic [1:0] size, input logic [13:0] addr);
      return (size == 2'd3) || ((int'(addr) % nbytes(size)) != 0);
   endfunction

   function automatic logic [31:0] model_load(input logic [13:0] addr, input logic [1:0] size,
                                              input logic uns);
      longint v = 0;
      int n = nbytes(size);
      for (int k = 0; k < n; k++)
         v += longint'(ref_mem[(int'(addr) + k) % 16384]) << (8 * k);
      if (!uns && n < 4 && v >= (longint'(1) << (8 * n - 1)))
         v -= (longint'(1) << (8 * n));
      return v[31:0];
   endfunction

   task automatic model_store(input logic [13:0] addr, input logic [1:0] size,
                              input logic [31:0] wdata);
      for (int k = 0; k < nbytes(size); k++)
         ref_mem[(int'(addr) + k) % 16384] = 8'((wdata >> (8 * k)) & 32'hFF);
   endtask

   task automatic run_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [13:0] addr, input logic [31:0] wdata,
                          input logic [3:0] tag, input int hold,
                          output int lat, output logic [31:0] rdata, output logic err,
                          output logic [3:0] otag, output bit stable, output bit dropped);
      wr_log.delete();
      rd_log.delete();
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
      req_addr = addr; req_wdata = wdata; req_tag = tag;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_we = 1'($urandom); req_size = 2'($urandom); req_unsigned = 1'($urandom);
      req_addr = 14'($urandom); req_wdata = $urandom; req_tag = 4'($urandom);
      lat = 0;
      while (resp_valid !== 1'b1 && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      rdata = resp_rdata; err = resp_err; otag = resp_tag;
      stable = 1'b1;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         #1;
         if (resp_valid !== 1'b1 || resp_rdata !== rdata || resp_err !== err ||
             resp_tag !== otag || req_ready !== 1'b0)
            stable = 1'b0;
      end
      resp_ready = 1'b1;
      @(posedge clk);
      #1;
      resp_ready = 1'b0;
      dropped = (resp_valid === 1'b0) && (req_ready === 1'b1);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      req_valid = 0; req_we = 0; req_size = 0; req_unsigned = 0;
      req_addr = 0; req_wdata = 0; req_tag = 0; resp_ready = 0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (req_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_req_ready got=%b want=1", req_ready);
      end
      checks++;
      if ({resp_valid, resp_rdata, resp_tag, resp_err, bram_ena, bram_wea, bram_addra,
           bram_dina, bram_enb, bram_addrb} !== '0) begin
         failures++;
         $display("FAIL reset_outputs_zero valid=%b rdata=%h ena=%b enb=%b",
                  resp_valid, resp_rdata, bram_ena, bram_enb);
      end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
         failures++;
         $display("FAIL post_reset_idle ready=%b valid=%b", req_ready, resp_valid);
      end
   endtask

   task automatic test_word_store_load;
      int lat; logic [31:0] rd; logic er; logic [3:0] tg; bit st, dr;
      logic [21:0] exp_wr [4] = '{{14'h100, 8'hEF}, {14'h101, 8'hBE},
                                  {14'h102, 8'hAD}, {14'h103, 8'hDE}};
      run_req(1, 2'd2, 0, 14'h0100, 32'hDEADBEEF, 4'h3, 0, lat, rd, er, tg, st, dr);
      model_store(14'h0100, 2'd2, 32'hDEADBEEF);
      checks++;
      if (lat !== 4 || er !== 1'b0 || rd !== 32'd0 || tg !== 4'h3) begin
         failures++;
         $display("FAIL store_word_resp lat=%0d err=%b rdata=%h tag=%h want lat=4 err=0 rdata=0 tag=3",
                  lat, er, rd, tg);
      end
      checks++;
      if (wr_log.size() != 4 || rd_log.size() != 0) begin
         failures++;
         $display("FAIL store_word_port_count wr=%0d rd=%0d want wr=4 rd=0", wr_log.size(), rd_log.size());
      end else begin
         for (int k = 0; k < 4; k++) begin
            checks++;
            if (wr_log[k] !== exp_wr[k]) begin
               failures++;
               $display("FAIL store_word_byte%0d got=%h want=%h", k, wr_log[k], exp_wr[k]);
            end
         end
      end
      run_req(0, 2'd2, 0, 14'h0100, 32'h0, 4'h5, 0, lat, rd, er, tg, st, dr);
      checks++;
      if (lat !== 5 || rd !== 32'hDEADBEEF || tg !== 4'h5 || er !== 1'b0 || !dr) begin
         failures++;
         $display("FAIL load_word lat=%0d rdata=%h tag=%h err=%b drop=%b want lat=5 rdata=deadbeef tag=5",
                  lat, rd, tg, er, dr);
      end
      checks++;
      if (rd_log.size() != 4 || wr_log.size() != 0 || rd_log[0] !== 14'h100 || rd_log[3] !== 14'h103) begin
         failures++;
         $display("FAIL load_word_port rd=%0d wr=%0d", rd_log.size(), wr_log.size());
      end
   endtask

   task automatic test_subword;
      int lat; logic [31:0] rd; logic er; logic [3:0] tg; bit st, dr;
      logic [1:0]  sz [4] = '{2'd0, 2'd0, 2'd1, 2'd1};
      logic        un [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
      logic [13:0] ad [4] = '{14'h103, 14'h103, 14'h102, 14'h100};
      logic [31:0] ex [4] = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDEAD, 32'h0000BEEF};
      for (int i = 0; i < 4; i++) begin
         run_req(0, sz[i], un[i], ad[i], 32'h0, 4'(i + 8), 0, lat, rd, er, tg, st, dr);
         checks++;
         if (rd !== ex[i] || lat !== nbytes(sz[i]) + 1 || tg !== 4'(i + 8)) begin
            failures++;
            $display("FAIL subword_load%0d rdata=%h lat=%0d tag=%h want rdata=%h lat=%0d",
                     i, rd, lat, tg, ex[i], nbytes(sz[i]) + 1);
         end
      end
   endtask

   task automatic test_errors;
      int lat; logic [31:0] rd; logic er; logic [3:0] tg; bit st, dr;
      logic        we [3] = '{1'b0, 1'b1, 1'b0};
      logic [1:0]  sz [3] = '{2'd2, 2'd1, 2'd3};
      logic [13:0] ad [3] = '{14'h0101, 14'h0203, 14'h0000};
      for (int i = 0; i < 3; i++) begin
         run_req(we[i], sz[i], 0, ad[i], 32'hFFFFFFFF, 4'(i + 1), 0, lat, rd, er, tg, st, dr);
         checks++;
         if (er !== 1'b1 || rd !== 32'd0 || lat !== 1 || tg !== 4'(i + 1)) begin
            failures++;
            $display("FAIL error_resp%0d err=%b rdata=%h lat=%0d tag=%h want err=1 rdata=0 lat=1",
                     i, er, rd, lat, tg);
         end
         checks++;
         if (wr_log.size() != 0 || rd_log.size() != 0) begin
            failures++;
            $display("FAIL error_no_bram%0d ena_pulses=%0d enb_pulses=%0d want 0",
                     i, wr_log.size(), rd_log.size());
         end
      end
   endtask

   task automatic test_back_to_back;
      int lat; logic [31:0] rd; logic er; logic [3:0] tg; bit st, dr;
      run_req(0, 2'd1, 0, 14'h0102, 32'h0, 4'hA, 3, lat, rd, er, tg, st, dr);
      checks++;
      if (!st || !dr || rd !== 32'hFFFFDEAD) begin
         failures++;
         $display("FAIL backpressure_hold stable=%b dropped=%b rdata=%h want 1 1 ffffdead", st, dr, rd);
      end
      // load with a queued follow-up request waiting through the response hold
      @(negedge clk);
      req_valid = 1; req_we = 0; req_size = 2'd0; req_unsigned = 1; req_addr = 14'h0101; req_tag = 4'h6;
      @(posedge clk);
      #1;
      req_size = 2'd2; req_unsigned = 0; req_addr = 14'h0100; req_tag = 4'h7;
      lat = 0;
      while (resp_valid !== 1'b1 && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      checks++;
      if (resp_rdata !== 32'h000000BE || resp_tag !== 4'h6 || lat !== 2) begin
         failures++;
         $display("FAIL queued_first rdata=%h tag=%h lat=%0d want be 6 2", resp_rdata, resp_tag, lat);
      end
      st = 1;
      repeat (3) begin
         @(posedge clk);
         #1;
         if (req_ready !== 1'b0 || resp_valid !== 1'b1 || resp_tag !== 4'h6) st = 0;
      end
      checks++;
      if (!st) begin
         failures++;
         $display("FAIL queued_hold ready=%b valid=%b want ready=0 valid=1", req_ready, resp_valid);
      end
      resp_ready = 1;
      @(posedge clk);
      #1;
      resp_ready = 0;
      checks++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
         failures++;
         $display("FAIL handshake_to_idle valid=%b ready=%b want 0 1", resp_valid, req_ready);
      end
      @(posedge clk);
      #1;
      req_valid = 0;
      checks++;
      if (req_ready !== 1'b0) begin
         failures++;
         $display("FAIL queued_accept ready=%b want 0", req_ready);
      end
      lat = 0;
      while (resp_valid !== 1'b1 && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      checks++;
      if (resp_rdata !== 32'hDEADBEEF || resp_tag !== 4'h7 || lat !== 5) begin
         failures++;
         $display("FAIL queued_second rdata=%h tag=%h lat=%0d want deadbeef 7 5", resp_rdata, resp_tag, lat);
      end
      resp_ready = 1;
      @(posedge clk);
      #1;
      resp_ready = 0;
   endtask

   task automatic test_top_of_memory;
      int lat; logic [31:0] rd; logic er; logic [3:0] tg; bit st, dr;
      run_req(1, 2'd2, 0, 14'h3FFC, 32'h11223344, 4'h1, 0, lat, rd, er, tg, st, dr);
      model_store(14'h3FFC, 2'd2, 32'h11223344);
      checks++;
      if (lat !== 4 || er !== 1'b0 || wr_log.size() != 4 || wr_log[3] !== {14'h3FFF, 8'h11}) begin
         failures++;
         $display("FAIL top_store lat=%0d err=%b writes=%0d", lat, er, wr_log.size());
      end
      run_req(0, 2'd0, 0, 14'h3FFF, 32'h0, 4'h2, 0, lat, rd, er, tg, st, dr);
      checks++;
      if (rd !== 32'h00000011) begin
         failures++;
         $display("FAIL top_byte_load got=%h want=00000011", rd);
      end
      run_req(0, 2'd1, 0, 14'h3FFE, 32'h0, 4'h3, 0, lat, rd, er, tg, st, dr);
      checks++;
      if (rd !== 32'h00001122) begin
         failures++;
         $display("FAIL top_half_load got=%h want=00001122", rd);
      end
   endtask

   task automatic test_reset_mid_store;
      int lat; logic [31:0] rd; logic er; logic [3:0] tg; bit st, dr, seen;
      logic [7:0] ex [4] = '{8'hA5, 8'hA5, 8'h00, 8'h00};
      for (int k = 0; k < 4; k++) begin
         mem[14'h200 + k] = 8'h00;
         ref_mem[14'h200 + k] = 8'h00;
      end
      @(negedge clk);
      req_valid = 1; req_we = 1; req_size = 2'd2; req_addr = 14'h0200; req_wdata = 32'hA5A5A5A5; req_tag = 4'h9;
      @(posedge clk);
      #1;
      req_valid = 0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1;
      #1;
      checks++;
      if (req_ready !== 1'b1 || {resp_valid, resp_rdata, resp_tag, resp_err, bram_ena, bram_wea,
          bram_addra, bram_dina, bram_enb, bram_addrb} !== '0) begin
         failures++;
         $display("FAIL reset_abort_outputs ready=%b ena=%b valid=%b", req_ready, bram_ena, resp_valid);
      end
      @(negedge clk);
      @(negedge clk);
      rst = 0;
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (mem[14'h200 + k] !== ex[k]) begin
            failures++;
            $display("FAIL reset_abort_mem%0d got=%h want=%h", k, mem[14'h200 + k], ex[k]);
         end
      end
      ref_mem[14'h200] = 8'hA5;
      ref_mem[14'h201] = 8'hA5;
      seen = 0;
      repeat (4) begin
         @(posedge clk);
         #1;
         if (resp_valid !== 1'b0) seen = 1;
      end
      checks++;
      if (seen) begin
         failures++;
         $display("FAIL reset_abort_no_resp resp_valid seen=1 want 0");
      end
      run_req(0, 2'd2, 0, 14'h0200, 32'h0, 4'hC, 0, lat, rd, er, tg, st, dr);
      checks++;
      if (rd !== 32'h0000A5A5 || lat !== 5 || tg !== 4'hC) begin
         failures++;
         $display("FAIL after_reset_load rdata=%h lat=%0d tag=%h want 0000a5a5 5 c", rd, lat, tg);
      end
   endtask

   task automatic test_random;
      int lat, n, exp_lat; logic [31:0] rd, wd, exp_rd; logic er; logic [3:0] tg, t;
      bit st, dr, e, w, u; logic [1:0] sz; logic [13:0] ad; int hold;
      for (int i = 0; i < 60; i++) begin
         w = 1'($urandom); u = 1'($urandom); sz = 2'($urandom_range(0, 3));
         ad = 14'h1000 + 14'($urandom_range(0, 31));
         n = nbytes(sz);
         if ($urandom_range(0, 3) != 0) ad = 14'((int'(ad) / n) * n);
         wd = $urandom; t = 4'($urandom); hold = $urandom_range(0, 2);
         e = model_err(sz, ad);
         exp_rd = (e || w) ? 32'd0 : model_load(ad, sz, u);
         exp_lat = e ? 1 : (w ? n : n + 1);
         run_req(w, sz, u, ad, wd, t, hold, lat, rd, er, tg, st, dr);
         checks++;
         if (rd !== exp_rd || er !== e || tg !== t || lat !== exp_lat || !st || !dr) begin
            failures++;
            $display("FAIL rand%0d we=%b sz=%0d addr=%h rdata=%h/%h err=%b/%b tag=%h/%h lat=%0d/%0d st=%b dr=%b",
                     i, w, sz, ad, rd, exp_rd, er, e, tg, t, lat, exp_lat, st, dr);
         end
         checks++;
         if (wr_log.size() != ((!e && w) ? n : 0) || rd_log.size() != ((!e && !w) ? n : 0)) begin
            failures++;
            $display("FAIL rand%0d_port_count wr=%0d rd=%0d", i, wr_log.size(), rd_log.size());
         end else if (!e) begin
            for (int k = 0; k < n; k++) begin
               checks++;
               if (w ? (wr_log[k] !== {14'(ad + 14'(k)), 8'(wd >> (8 * k))})
                     : (rd_log[k] !== 14'(ad + 14'(k)))) begin
                  failures++;
                  $display("FAIL rand%0d_byte%0d addr=%h", i, k, ad);
               end
            end
         end
         if (!e && w) model_store(ad, sz, wd);
      end
   endtask

   initial begin
      rst = 1'b1;
      resp_ready = 1'b0;
      for (int i = 0; i < 16384; i++) begin
         mem[i] = 8'h00;
         ref_mem[i] = 8'h00;
      end
      test_reset();
      test_word_store_load();
      test_subword();
      test_errors();
      test_back_to_back();
      test_top_of_memory();
      test_reset_mid_store();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
